mmio_memory: RTL

MMIO_MEMORY -- requirements
Module: mmio_memory

---
 rtl/mmio_memory_pkg.sv | 49 ++++
 rtl/mmio_key_capture.sv | 62 ++++++
 rtl/mmio_memory.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/mmio_memory_pkg.sv
// -----------------------------------------------------------------------------
// mmio_memory_pkg
// Shared memory-map definitions for the processor and the mmio_memory block:
// MMIO base address, per-register word addresses, the decoded region type and
// an address-decode helper.
// -----------------------------------------------------------------------------
package mmio_memory_pkg;

    // MMIO registers sit at the very top of the 30-bit word address space
    localparam logic [29:0] MMIO_BASE_ADDR   = 30'h3FFF_FFC0;
    localparam logic [29:0] MMIO_HEX_ADDR    = MMIO_BASE_ADDR + 30'd0;
    localparam logic [29:0] MMIO_LEDR_ADDR   = MMIO_BASE_ADDR + 30'd1;
    localparam logic [29:0] MMIO_KEY_ADDR    = MMIO_BASE_ADDR + 30'd2;
    localparam logic [29:0] MMIO_KEYCAP_ADDR = MMIO_BASE_ADDR + 30'd3;
    localparam logic [29:0] MMIO_SW_ADDR     = MMIO_BASE_ADDR + 30'd4;
    localparam logic [29:0] MMIO_TIMER_ADDR  = MMIO_BASE_ADDR + 30'd5;

    typedef enum logic [2:0] {
        REGION_RAM    = 3'd0,
        REGION_HEX    = 3'd1,
        REGION_LEDR   = 3'd2,
        REGION_KEY    = 3'd3,
        REGION_KEYCAP = 3'd4,
        REGION_SW     = 3'd5,
        REGION_TIMER  = 3'd6,
        REGION_NONE   = 3'd7
    } region_e;

    // RAM occupies word addresses below 2^ram_aw; anything that is neither RAM
    // nor one of the MMIO registers decodes as unmapped.
    function automatic region_e decode_region(input logic [29:0] addr, input int ram_aw);
        region_e region;
        if ((addr >> ram_aw) == 30'd0) begin
            region = REGION_RAM;
        end else begin
            case (addr)
                MMIO_HEX_ADDR:    region = REGION_HEX;
                MMIO_LEDR_ADDR:   region = REGION_LEDR;
                MMIO_KEY_ADDR:    region = REGION_KEY;
                MMIO_KEYCAP_ADDR: region = REGION_KEYCAP;
                MMIO_SW_ADDR:     region = REGION_SW;
                MMIO_TIMER_ADDR:  region = REGION_TIMER;
                default:          region = REGION_NONE;
            endcase
        end
        return region;
    endfunction

endpackage

// File: rtl/mmio_key_capture.sv
// -----------------------------------------------------------------------------
// mmio_key_capture
// Two-flop synchroniser for the active-low push-buttons plus a sticky
// press-capture register (KEYCAP) with write-1-to-clear.
//   clk, reset : clock, asynchronous active-low reset
//   key_in     : raw buttons, active-low, asynchronous
//   clr_en     : W1C write strobe for KEYCAP
//   clr_mask   : bits to clear when clr_en is high
//   key_sync   : synchronised button levels
//   keycap     : captured presses (bit set on a synchronised 1->0 edge)
// -----------------------------------------------------------------------------
module mmio_key_capture #(
    parameter int KEY_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [KEY_WIDTH-1:0] key_in,
    input  logic                 clr_en,
    input  logic [KEY_WIDTH-1:0] clr_mask,
    output logic [KEY_WIDTH-1:0] key_sync,
    output logic [KEY_WIDTH-1:0] keycap
);

    logic [KEY_WIDTH-1:0] key_meta_q, key_meta_d;
    logic [KEY_WIDTH-1:0] key_sync_q, key_sync_d;
    logic [KEY_WIDTH-1:0] key_prev_q, key_prev_d;
    logic [KEY_WIDTH-1:0] keycap_q,   keycap_d;
    logic [KEY_WIDTH-1:0] clr_bits_s;

    // Next-state: synchroniser shift, edge history, and KEYCAP set/clear
    always_comb begin
        key_meta_d = key_in;
        key_sync_d = key_meta_q;
        key_prev_d = key_sync_q;
        if (clr_en) begin
            clr_bits_s = clr_mask;
        end else begin
            clr_bits_s = '0;
        end
        // The press term is OR-ed in after the clear, so a press wins a tie
        keycap_d = (keycap_q & ~clr_bits_s) | (key_prev_q & ~key_sync_q);
    end

    // State registers; button history resets to all-ones (released)
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            key_meta_q <= '1;
            key_sync_q <= '1;
            key_prev_q <= '1;
            keycap_q   <= '0;
        end else begin
            key_meta_q <= key_meta_d;
            key_sync_q <= key_sync_d;
            key_prev_q <= key_prev_d;
            keycap_q   <= keycap_d;
        end
    end

    assign key_sync = key_sync_q;
    assign keycap   = keycap_q;

endmodule

// File: rtl/mmio_memory.sv
// -----------------------------------------------------------------------------
// mmio_memory
// Word-addressed data memory with byte-lane writes and a small MMIO register
// file (HEX, LEDR, KEY, KEYCAP, SW, TIMER). Reads are two-stage: the request
// is sampled (read-first) on one edge and presented on data_out/rd_valid on
// the next.
//   clk, reset          : clock, asynchronous active-low reset
//   addr, rd_en, wr_en  : word address and request strobes
//   byte_en, data_in    : write lanes (RAM only) and write data
//   data_out, rd_valid  : read data and its one-cycle valid
//   addr_err            : one-cycle pulse for an unmapped access
//   mmio_key_in/sw_in   : raw asynchronous buttons / switches
//   mmio_hex_out/ledr_out : HEX and LEDR register contents
// -----------------------------------------------------------------------------
module mmio_memory
    import mmio_memory_pkg::*;
#(
    parameter string MEM_INIT_FILE  = "",
    parameter int    ADDR_BIT_WIDTH = 11,
    parameter int    DATA_BIT_WIDTH = 32,
    parameter int    HEX_DIGITS     = 4,
    parameter int    LEDR_WIDTH     = 10,
    parameter int    KEY_WIDTH      = 4,
    parameter int    SW_WIDTH       = 10,
    parameter int    TIMER_DIV      = 50000
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [29:0]                 addr,
    input  logic                        rd_en,
    input  logic                        wr_en,
    input  logic [DATA_BIT_WIDTH/8-1:0] byte_en,
    input  logic [DATA_BIT_WIDTH-1:0]   data_in,
    output logic [DATA_BIT_WIDTH-1:0]   data_out,
    output logic                        rd_valid,
    output logic                        addr_err,
    input  logic [KEY_WIDTH-1:0]        mmio_key_in,
    input  logic [SW_WIDTH-1:0]         mmio_sw_in,
    output logic [4*HEX_DIGITS-1:0]     mmio_hex_out,
    output logic [LEDR_WIDTH-1:0]       mmio_ledr_out
);

    localparam int NUM_LANES = DATA_BIT_WIDTH / 8;
    localparam int HEX_W     = 4 * HEX_DIGITS;
    localparam int RAM_DEPTH = 1 << ADDR_BIT_WIDTH;
    localparam int PRESC_W   = (TIMER_DIV > 1) ? $clog2(TIMER_DIV) : 1;

    // RAM preload from MEM_INIT_FILE is applied by the implementation flow's
    // memory-initialisation step; an empty name leaves contents undefined.
    if (MEM_INIT_FILE != "") begin : g_mem_init_file
    end

    region_e                    region_s;
    logic                       ram_rd_s, ram_wr_s, keycap_clr_s;
    logic [ADDR_BIT_WIDTH-1:0]  ram_idx_s;
    logic [DATA_BIT_WIDTH-1:0]  mmio_rdata_s;
    logic [KEY_WIDTH-1:0]       key_sync_s, keycap_s;

    logic [DATA_BIT_WIDTH-1:0]  mem [0:RAM_DEPTH-1];
    logic [DATA_BIT_WIDTH-1:0]  ram_rdata_q;

    logic [SW_WIDTH-1:0]        sw_meta_q, sw_meta_d, sw_sync_q, sw_sync_d;
    logic [HEX_W-1:0]           hex_q, hex_d;
    logic [LEDR_WIDTH-1:0]      ledr_q, ledr_d;
    logic [DATA_BIT_WIDTH-1:0]  timer_q, timer_d;
    logic [PRESC_W-1:0]         presc_q, presc_d;

    // Stage 1: sampled read request; stage 2: registered outputs
    logic                       rd_pend_q, rd_pend_d, rd_ram_q, rd_ram_d;
    logic                       rd_err_q, rd_err_d, wr_err_q, wr_err_d;
    logic [DATA_BIT_WIDTH-1:0]  mmio_rdata_q, mmio_rdata_d;
    logic [DATA_BIT_WIDTH-1:0]  data_out_q, data_out_d;
    logic                       rd_valid_q, rd_valid_d, addr_err_q, addr_err_d;

    // Address decode and per-target strobes
    always_comb begin
        region_s     = decode_region(addr, ADDR_BIT_WIDTH);
        ram_idx_s    = addr[ADDR_BIT_WIDTH-1:0];
        ram_rd_s     = rd_en && (region_s == REGION_RAM);
        ram_wr_s     = wr_en && (region_s == REGION_RAM);
        keycap_clr_s = wr_en && (region_s == REGION_KEYCAP);
    end

    // RAM: lane-masked writes; the read register samples the pre-write word
    always_ff @(posedge clk) begin
        if (ram_rd_s) begin
            ram_rdata_q <= mem[ram_idx_s];
        end
        for (int i = 0; i < NUM_LANES; i++) begin
            if (ram_wr_s && byte_en[i]) begin
                mem[ram_idx_s][8*i +: 8] <= data_in[8*i +: 8];
            end
        end
    end

    mmio_key_capture #(
        .KEY_WIDTH (KEY_WIDTH)
    ) u_key_capture (
        .clk      (clk),
        .reset    (reset),
        .key_in   (mmio_key_in),
        .clr_en   (keycap_clr_s),
        .clr_mask (data_in[KEY_WIDTH-1:0]),
        .key_sync (key_sync_s),
        .keycap   (keycap_s)
    );

    // MMIO register next-state: switch synchroniser, HEX/LEDR writes, timer
    always_comb begin
        sw_meta_d = mmio_sw_in;
        sw_sync_d = sw_meta_q;
        hex_d     = hex_q;
        ledr_d    = ledr_q;
        if (presc_q == PRESC_W'(TIMER_DIV - 1)) begin
            presc_d = '0;
            timer_d = timer_q + DATA_BIT_WIDTH'(1);
        end else begin
            presc_d = presc_q + PRESC_W'(1);
            timer_d = timer_q;
        end
        if (wr_en) begin
            case (region_s)
                REGION_HEX:   hex_d  = data_in[HEX_W-1:0];
                REGION_LEDR:  ledr_d = data_in[LEDR_WIDTH-1:0];
                REGION_TIMER: begin
                    timer_d = data_in;
                    presc_d = '0;
                end
                default: ; // RAM/KEYCAP handled elsewhere; KEY/SW are read-only
            endcase
        end else begin
            hex_d = hex_q;
        end
    end

    // MMIO read mux; unmapped and RAM addresses read as zero here
    always_comb begin
        case (region_s)
            REGION_HEX:    mmio_rdata_s = DATA_BIT_WIDTH'(hex_q);
            REGION_LEDR:   mmio_rdata_s = DATA_BIT_WIDTH'(ledr_q);
            REGION_KEY:    mmio_rdata_s = DATA_BIT_WIDTH'(key_sync_s);
            REGION_KEYCAP: mmio_rdata_s = DATA_BIT_WIDTH'(keycap_s);
            REGION_SW:     mmio_rdata_s = DATA_BIT_WIDTH'(sw_sync_q);
            REGION_TIMER:  mmio_rdata_s = timer_q;
            default:       mmio_rdata_s = '0;
        endcase
    end

    // Read pipeline next-state and error pulses
    always_comb begin
        rd_pend_d = rd_en;
        rd_ram_d  = ram_rd_s;
        rd_err_d  = rd_en && (region_s == REGION_NONE);
        wr_err_d  = wr_en && (region_s == REGION_NONE);
        if (rd_en) begin
            mmio_rdata_d = mmio_rdata_s;
        end else begin
            mmio_rdata_d = mmio_rdata_q;
        end
        if (rd_pend_q) begin
            data_out_d = rd_ram_q ? ram_rdata_q : mmio_rdata_q;
        end else begin
            data_out_d = data_out_q;
        end
        rd_valid_d = rd_pend_q;
        addr_err_d = rd_err_q | wr_err_q;
    end

    // All control and MMIO state; RAM contents are deliberately not reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sw_meta_q    <= '0;
            sw_sync_q    <= '0;
            hex_q        <= '0;
            ledr_q       <= '0;
            timer_q      <= '0;
            presc_q      <= '0;
            rd_pend_q    <= 1'b0;
            rd_ram_q     <= 1'b0;
            rd_err_q     <= 1'b0;
            wr_err_q     <= 1'b0;
            mmio_rdata_q <= '0;
            data_out_q   <= '0;
            rd_valid_q   <= 1'b0;
            addr_err_q   <= 1'b0;
        end else begin
            sw_meta_q    <= sw_meta_d;
            sw_sync_q    <= sw_sync_d;
            hex_q        <= hex_d;
            ledr_q       <= ledr_d;
            timer_q      <= timer_d;
            presc_q      <= presc_d;
            rd_pend_q    <= rd_pend_d;
            rd_ram_q     <= rd_ram_d;
            rd_err_q     <= rd_err_d;
            wr_err_q     <= wr_err_d;
            mmio_rdata_q <= mmio_rdata_d;
            data_out_q   <= data_out_d;
            rd_valid_q   <= rd_valid_d;
            addr_err_q   <= addr_err_d;
        end
    end

    assign data_out      = data_out_q;
    assign rd_valid      = rd_valid_q;
    assign addr_err      = addr_err_q;
    assign mmio_hex_out  = hex_q;
    assign mmio_ledr_out = ledr_q;

endmodule
